lsu_ahb_master: RTL and testbench

- Parametrised AHB-Lite data-side master between the LSU and the system AHB bus; next generation of the single-outstanding load/store bus interface.
- Adds byte/half/word sizes, a posted-write buffer of configurable depth, pipelined back-to-back write issue, misalignment detection and two-cycle HRESP error handling.
- Loads bypass the buffer only after it drains, so memory ordering is preserved.

---
 rtl/ahb_pkg.sv | 29 ++
 rtl/lsu_wbuf_fifo.sv | 60 ++++++
 rtl/lsu_ahb_master.sv | 157 +++++++++++++++
 tb/tb_lsu_ahb_master.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and helpers for the LSU data-side bus master.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HSIZE_BYTE    = 3'b000;
  localparam logic [2:0] HSIZE_HALF    = 3'b001;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [3:0] HPROT_DATA    = 4'b0001;

  // Size 3 has no legal encoding on a 32-bit bus, so it is reported as misaligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case ({1'b0, size})
      HSIZE_BYTE: mis = 1'b0;
      HSIZE_HALF: mis = addr_lo[0];
      HSIZE_WORD: mis = (addr_lo != 2'b00);
      default:    mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_wbuf_fifo.sv
// Synchronous posted-write FIFO; head entry is visible combinationally on rdata_o.
module lsu_wbuf_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/lsu_ahb_master.sv
// AHB-Lite data-side master for the LSU: posted-write buffer, pipelined writes,
// loads issued only once all earlier stores have left the bus.
module lsu_ahb_master
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned WBUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [1:0]        size_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              gnt_o,
  output logic              stallreq_o,
  output logic              rvalid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              lerr_o,
  output logic              werr_o,
  output logic              wbuf_empty_o,
  output logic [ADDR_W-1:0] haddr_o,
  output logic [1:0]        htrans_o,
  output logic              hwrite_o,
  output logic [2:0]        hsize_o,
  output logic [2:0]        hburst_o,
  output logic [3:0]        hprot_o,
  output logic              hmastlock_o,
  output logic [DATA_W-1:0] hwdata_o,
  input  logic [DATA_W-1:0] hrdata_i,
  input  logic              hready_i,
  input  logic              hresp_i
);

  localparam int unsigned ENTRY_W = ADDR_W + 2 + DATA_W;

  if (DATA_W != 32) begin : g_bad_data_w
    $error("lsu_ahb_master: DATA_W must be 32");
  end
  if (WBUF_DEPTH < 1 || WBUF_DEPTH > 8) begin : g_bad_depth
    $error("lsu_ahb_master: WBUF_DEPTH must be in 1..8");
  end

  logic               fifo_full, fifo_empty, fifo_pop_c;
  logic [ENTRY_W-1:0] fifo_head;
  logic [ADDR_W-1:0]  head_addr;
  logic [1:0]         head_size;
  logic [DATA_W-1:0]  head_wdata;

  logic               dp_valid_q, dp_valid_d, dp_write_q, dp_write_d;
  logic [DATA_W-1:0]  dp_wdata_q, dp_wdata_d;
  logic               rvalid_q, rvalid_d, lerr_q, lerr_d, werr_q, werr_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;

  logic mis_c, ld_req_c, st_req_c, err_cancel_c, rd_dp_c, rd_done_c, wr_err_c;
  logic load_ok_c, mis_ld_gnt_c, st_gnt_c, mis_st_gnt_c, issue_c, acc_c;

  lsu_wbuf_fifo #(.WIDTH(ENTRY_W), .DEPTH(WBUF_DEPTH)) u_wbuf (
    .clk     (clk),
    .rst     (rst),
    .push_i  (st_gnt_c),
    .wdata_i ({addr_i, size_i, wdata_i}),
    .pop_i   (fifo_pop_c),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head_addr  = fifo_head[ENTRY_W-1 -: ADDR_W];
  assign head_size  = fifo_head[DATA_W +: 2];
  assign head_wdata = fifo_head[DATA_W-1:0];

  // Request classification and grant.
  assign mis_c        = is_misaligned(size_i, addr_i[1:0]);
  assign ld_req_c     = req_i & ~we_i;
  assign st_req_c     = req_i & we_i;
  assign err_cancel_c = dp_valid_q & hresp_i;
  assign rd_dp_c      = dp_valid_q & ~dp_write_q;
  assign rd_done_c    = rd_dp_c & hready_i;
  assign wr_err_c     = dp_valid_q & dp_write_q & hready_i & hresp_i;
  assign load_ok_c    = ld_req_c & ~mis_c & fifo_empty & ~dp_valid_q & hready_i;
  assign mis_ld_gnt_c = ld_req_c & mis_c & ~rd_dp_c;
  assign st_gnt_c     = st_req_c & ~mis_c & ~fifo_full;
  assign mis_st_gnt_c = st_req_c & mis_c & ~wr_err_c;
  assign gnt_o        = st_gnt_c | mis_st_gnt_c | load_ok_c | mis_ld_gnt_c;
  assign stallreq_o   = req_i & ~gnt_o;

  // Address phase: buffered stores drain ahead of any load.
  assign issue_c    = (~fifo_empty | load_ok_c) & ~err_cancel_c;
  assign acc_c      = issue_c & hready_i;
  assign fifo_pop_c = acc_c & ~fifo_empty;

  always_comb begin
    htrans_o = HTRANS_IDLE;
    haddr_o  = '0;
    hwrite_o = 1'b0;
    hsize_o  = HSIZE_BYTE;
    if (!fifo_empty) begin
      haddr_o  = head_addr;
      hwrite_o = 1'b1;
      hsize_o  = {1'b0, head_size};
    end else if (load_ok_c) begin
      haddr_o  = addr_i;
      hsize_o  = {1'b0, size_i};
    end
    if (issue_c) htrans_o = HTRANS_NONSEQ;
  end

  assign hburst_o     = HBURST_SINGLE;
  assign hprot_o      = HPROT_DATA;
  assign hmastlock_o  = 1'b0;
  assign hwdata_o     = dp_wdata_q;
  assign rvalid_o     = rvalid_q;
  assign rdata_o      = rdata_q;
  assign lerr_o       = lerr_q;
  assign werr_o       = werr_q;
  assign wbuf_empty_o = fifo_empty & ~(dp_valid_q & dp_write_q);

  // Data-phase tracking advances only when the current data phase completes.
  always_comb begin
    dp_valid_d = dp_valid_q;
    dp_write_d = dp_write_q;
    dp_wdata_d = dp_wdata_q;
    if (hready_i) begin
      dp_valid_d = acc_c;
      dp_write_d = fifo_pop_c;
      if (fifo_pop_c) dp_wdata_d = head_wdata;
    end
    rvalid_d = rd_done_c | mis_ld_gnt_c;
    lerr_d   = (rd_done_c & hresp_i) | mis_ld_gnt_c;
    rdata_d  = (rd_done_c & ~hresp_i) ? hrdata_i : '0;
    werr_d   = wr_err_c | mis_st_gnt_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_wdata_q <= '0;
      rvalid_q   <= 1'b0;
      lerr_q     <= 1'b0;
      rdata_q    <= '0;
      werr_q     <= 1'b0;
    end else begin
      dp_valid_q <= dp_valid_d;
      dp_write_q <= dp_write_d;
      dp_wdata_q <= dp_wdata_d;
      rvalid_q   <= rvalid_d;
      lerr_q     <= lerr_d;
      rdata_q    <= rdata_d;
      werr_q     <= werr_d;
    end
  end

endmodule

// File: tb/tb_lsu_ahb_master.sv
// Directed bench for lsu_ahb_master with an AHB slave model and load/store scoreboards.
module tb_lsu_ahb_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_i = 1'b0, we_i = 1'b0;
  logic [1:0]  size_i = 2'd0;
  logic [31:0] addr_i = '0, wdata_i = '0;
  logic        gnt_o, stallreq_o, rvalid_o, lerr_o, werr_o, wbuf_empty_o;
  logic [31:0] rdata_o, haddr_o, hwdata_o;
  logic [1:0]  htrans_o;
  logic        hwrite_o, hmastlock_o;
  logic [2:0]  hsize_o, hburst_o;
  logic [3:0]  hprot_o;
  logic [31:0] hrdata_i;
  logic        hready_i, hresp_i;

  lsu_ahb_master #(.ADDR_W(32), .DATA_W(32), .WBUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .size_i(size_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .gnt_o(gnt_o), .stallreq_o(stallreq_o), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .lerr_o(lerr_o), .werr_o(werr_o), .wbuf_empty_o(wbuf_empty_o),
    .haddr_o(haddr_o), .htrans_o(htrans_o), .hwrite_o(hwrite_o), .hsize_o(hsize_o),
    .hburst_o(hburst_o), .hprot_o(hprot_o), .hmastlock_o(hmastlock_o), .hwdata_o(hwdata_o),
    .hrdata_i(hrdata_i), .hready_i(hready_i), .hresp_i(hresp_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct packed { logic err; logic [31:0] data; } rd_t;
  typedef struct packed { logic err; logic [31:0] addr; logic [31:0] data; } wr_t;
  rd_t rd_exp[$];
  wr_t wr_exp[$];

  logic [31:0] mem    [0:16383];
  logic [31:0] shadow [0:16383];

  // Slave model: programmable wait states and a one-shot two-cycle ERROR on err_addr.
  logic        s_act = 1'b0, s_write = 1'b0;
  logic [31:0] s_addr = '0;
  int          s_cnt = 0, s_err = 0;
  int          wait_states = 0;
  logic        err_en = 1'b0;
  logic [31:0] err_addr = '0;

  always_comb begin
    hready_i = 1'b1;
    hresp_i  = 1'b0;
    hrdata_i = '0;
    if (s_act) begin
      if (s_err == 1) begin
        hready_i = 1'b0;
        hresp_i  = 1'b1;
      end else if (s_err == 2) begin
        hresp_i  = 1'b1;
      end else begin
        hready_i = (s_cnt == 0);
        if (!s_write) hrdata_i = mem[s_addr[15:2]];
      end
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      s_act <= 1'b0;
      s_err <= 0;
      s_cnt <= 0;
    end else if (hready_i) begin
      if (s_act && s_write) begin
        if (wr_exp.size() == 0) chk("wr_sb_nonempty", 64'(wr_exp.size()), 64'd1);
        else begin
          wr_t e;
          e = wr_exp.pop_front();
          chk("wr_addr", 64'(s_addr), 64'(e.addr));
          chk("wr_err", 64'(hresp_i), 64'(e.err));
          if (!hresp_i) begin
            chk("wr_data", 64'(hwdata_o), 64'(e.data));
            mem[s_addr[15:2]] = hwdata_o;
          end
        end
      end
      if (htrans_o == 2'b10) begin
        s_act   <= 1'b1;
        s_write <= hwrite_o;
        s_addr  <= haddr_o;
        s_cnt   <= wait_states;
        if (err_en && haddr_o == err_addr) begin
          s_err  <= 1;
          err_en = 1'b0;
        end else s_err <= 0;
      end else begin
        s_act <= 1'b0;
        s_err <= 0;
      end
    end else begin
      if (s_err == 1) s_err <= 2;
      else if (s_cnt > 0) s_cnt <= s_cnt - 1;
    end
  end

  // Response monitor: load results against the scoreboard, store-error pulses counted.
  int werr_cnt = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (werr_o) werr_cnt++;
      if (rvalid_o) begin
        if (rd_exp.size() == 0) chk("rd_sb_nonempty", 64'(rd_exp.size()), 64'd1);
        else begin
          rd_t e;
          e = rd_exp.pop_front();
          chk("rdata", 64'(rdata_o), 64'(e.data));
          chk("lerr", 64'(lerr_o), 64'(e.err));
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, output int waited, output logic [1:0] tr,
                       output logic [31:0] ha, output logic [2:0] hs, output logic hw);
    logic mis, experr;
    waited = 0;
    @(negedge clk);
    req_i = 1'b1; we_i = we; size_i = sz; addr_i = a; wdata_i = wd;
    #1;
    while (!gnt_o && waited < 50) begin
      chk("stallreq_wait", 64'(stallreq_o), 64'd1);
      @(negedge clk);
      #1;
      waited++;
    end
    if (!gnt_o) chk("gnt_timeout", 64'(gnt_o), 64'd1);
    chk("stallreq_gnt", 64'(stallreq_o), 64'd0);
    tr = htrans_o; ha = haddr_o; hs = hsize_o; hw = hwrite_o;
    mis = (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00) || (sz == 2'd3);
    if (we) begin
      if (!mis) begin
        experr = err_en && (a == err_addr);
        wr_exp.push_back({experr, a, wd});
        if (sz == 2'd2 && !experr) shadow[a[15:2]] = wd;
      end
    end else begin
      if (mis) rd_exp.push_back({1'b1, 32'h0});
      else     rd_exp.push_back({1'b0, shadow[a[15:2]]});
    end
    @(posedge clk);
    #1;
    req_i = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    @(negedge clk);
    while (!wbuf_empty_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wbuf_empty_drain", 64'(wbuf_empty_o), 64'd1);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_htrans"}, 64'(htrans_o), 64'd0);
    chk({tag, "_gnt"}, 64'(gnt_o), 64'd0);
    chk({tag, "_wbuf_empty"}, 64'(wbuf_empty_o), 64'd1);
    chk({tag, "_rvalid"}, 64'(rvalid_o), 64'd0);
    chk({tag, "_werr"}, 64'(werr_o), 64'd0);
    chk({tag, "_haddr"}, 64'(haddr_o), 64'd0);
    chk({tag, "_hwdata"}, 64'(hwdata_o), 64'd0);
    chk({tag, "_hburst"}, 64'(hburst_o), 64'd0);
    chk({tag, "_hprot"}, 64'(hprot_o), 64'd1);
    chk({tag, "_hmastlock"}, 64'(hmastlock_o), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    logic [1:0] tr;
    logic [31:0] ha;
    logic [2:0] hs;
    logic hw;
    for (int i = 0; i < 16384; i++) begin
      mem[i] = '0;
      shadow[i] = '0;
    end
    mem[32'h1000 >> 2]    = 32'hDEADBEEF;
    shadow[32'h1000 >> 2] = 32'hDEADBEEF;

    // Reset and idle
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("post_reset");

    // Zero-wait word load
    wait_states = 0;
    issue(1'b0, 2'd2, 32'h1000, 32'h0, w, tr, ha, hs, hw);
    chk("ld_wait", 64'(w), 64'd0);
    chk("ld_htrans", 64'(tr), 64'd2);
    chk("ld_hwrite", 64'(hw), 64'd0);
    chk("ld_haddr", 64'(ha), 64'h1000);
    chk("ld_hsize", 64'(hs), 64'd2);
    @(negedge clk);
    chk("ld_rvalid_n1", 64'(rvalid_o), 64'd0);
    @(negedge clk);
    chk("ld_rvalid_n2", 64'(rvalid_o), 64'd1);

    // Back-to-back stores into a one-wait slave; the fourth finds the buffer full
    wait_states = 1;
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 2'd2, 32'h2000 + 32'(4 * i), 32'hA000_0000 + 32'(i), w, tr, ha, hs, hw);
      chk("st_b2b_wait", 64'(w), (i == 3) ? 64'd1 : 64'd0);
    end
    wait_empty();

    // Store then load of the same address: load held off until the write completes
    wait_states = 0;
    issue(1'b1, 2'd2, 32'h3000, 32'h1234_5678, w, tr, ha, hs, hw);
    issue(1'b0, 2'd2, 32'h3000, 32'h0, w, tr, ha, hs, hw);
    chk("raw_load_wait", 64'(w), 64'd2);
    chk("raw_load_haddr", 64'(ha), 64'h3000);
    repeat (3) @(negedge clk);

    // Misaligned half load, legal byte store, misaligned word store
    issue(1'b0, 2'd1, 32'h4001, 32'h0, w, tr, ha, hs, hw);
    chk("misld_htrans", 64'(tr), 64'd0);
    @(negedge clk);
    chk("misld_rvalid", 64'(rvalid_o), 64'd1);
    chk("misld_lerr", 64'(lerr_o), 64'd1);
    issue(1'b1, 2'd0, 32'h4003, 32'hEE00_0000, w, tr, ha, hs, hw);
    @(negedge clk);
    chk("bst_htrans", 64'(htrans_o), 64'd2);
    chk("bst_hsize", 64'(hsize_o), 64'd0);
    chk("bst_haddr", 64'(haddr_o), 64'h4003);
    chk("bst_hwrite", 64'(hwrite_o), 64'd1);
    issue(1'b1, 2'd2, 32'h4002, 32'h5555_5555, w, tr, ha, hs, hw);
    chk("misst_wait", 64'(w), 64'd0);
    @(negedge clk);
    chk("misst_werr", 64'(werr_o), 64'd1);
    wait_empty();

    // Two-cycle ERROR on 0x5000 with 0x5004 pipelined behind it
    err_addr = 32'h5000;
    err_en   = 1'b1;
    issue(1'b1, 2'd2, 32'h5000, 32'h5000_AAAA, w, tr, ha, hs, hw);
    issue(1'b1, 2'd2, 32'h5004, 32'h5004_BBBB, w, tr, ha, hs, hw);
    @(negedge clk);
    chk("err1_htrans", 64'(htrans_o), 64'd0);
    chk("err1_hready", 64'(hready_i), 64'd0);
    chk("err1_hresp", 64'(hresp_i), 64'd1);
    @(negedge clk);
    chk("err2_htrans", 64'(htrans_o), 64'd0);
    chk("err2_hready", 64'(hready_i), 64'd1);
    @(negedge clk);
    chk("err_werr_pulse", 64'(werr_o), 64'd1);
    chk("reissue_htrans", 64'(htrans_o), 64'd2);
    chk("reissue_haddr", 64'(haddr_o), 64'h5004);
    @(negedge clk);
    chk("err_werr_clear", 64'(werr_o), 64'd0);
    wait_empty();
    issue(1'b0, 2'd2, 32'h5004, 32'h0, w, tr, ha, hs, hw);
    repeat (3) @(negedge clk);

    chk("rd_sb_drained", 64'(rd_exp.size()), 64'd0);
    chk("wr_sb_drained", 64'(wr_exp.size()), 64'd0);
    chk("werr_total", 64'(werr_cnt), 64'd2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
